// File: rtl/fnd_axil_regs.sv
// AXI4-Lite register file (CTRL/VALUE/DP/SCRATCH) driving a 4-digit
// active-low common-anode seven-segment display through a time-multiplexed scan.
module fnd_axil_regs #(
   parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
   parameter int unsigned C_S_AXI_ADDR_WIDTH = 4,
   parameter int unsigned SCAN_DIV           = 100000
) (
   input  logic                            clock,
   input  logic                            reset,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
   input  logic [2:0]                      s_axi_awprot,
   input  logic                            s_axi_awvalid,
   output logic                            s_axi_awready,
   input  logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_wdata,
   input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
   input  logic                            s_axi_wvalid,
   output logic                            s_axi_wready,
   output logic [1:0]                      s_axi_bresp,
   output logic                            s_axi_bvalid,
   input  logic                            s_axi_bready,
   input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
   input  logic [2:0]                      s_axi_arprot,
   input  logic                            s_axi_arvalid,
   output logic                            s_axi_arready,
   output logic [C_S_AXI_DATA_WIDTH-1:0]   s_axi_rdata,
   output logic [1:0]                      s_axi_rresp,
   output logic                            s_axi_rvalid,
   input  logic                            s_axi_rready,
   output logic [3:0]                      fnd_com,
   output logic [7:0]                      fnd_font
);

   localparam int unsigned DW     = C_S_AXI_DATA_WIDTH;
   localparam int unsigned SW     = C_S_AXI_DATA_WIDTH / 8;
   localparam int unsigned RW     = C_S_AXI_ADDR_WIDTH - 2;
   localparam int unsigned NREG   = 4;
   localparam int unsigned CNT_W  = $clog2(SCAN_DIV);

   typedef enum logic {W_IDLE, W_RESP} w_state_t;
   typedef enum logic {R_IDLE, R_DATA} r_state_t;

   logic [DW-1:0] regs_q [NREG];

   w_state_t      w_state_q, w_state_d;
   logic          aw_done_q, aw_done_d, w_done_q, w_done_d;
   logic [RW-1:0] awaddr_q, awaddr_d;
   logic [DW-1:0] wdata_q, wdata_d;
   logic [SW-1:0] wstrb_q, wstrb_d;
   logic          awready_q, awready_d, wready_q, wready_d;
   logic          bvalid_q, bvalid_d, wr_en;

   r_state_t      r_state_q, r_state_d;
   logic          arready_q, arready_d, rvalid_q, rvalid_d;
   logic [DW-1:0] rdata_q, rdata_d;

   logic [CNT_W-1:0] scan_cnt_q;
   logic [1:0]       scan_idx_q;

   // Write channel: AW and W captured independently, register written when both are in
   always_comb begin
      w_state_d = w_state_q;
      aw_done_d = aw_done_q;
      w_done_d  = w_done_q;
      awaddr_d  = awaddr_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      awready_d = awready_q;
      wready_d  = wready_q;
      bvalid_d  = bvalid_q;
      wr_en     = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            if (s_axi_awvalid && awready_q) begin
               aw_done_d = 1'b1;
               awaddr_d  = s_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (s_axi_wvalid && wready_q) begin
               w_done_d = 1'b1;
               wdata_d  = s_axi_wdata;
               wstrb_d  = s_axi_wstrb;
            end
            if (aw_done_d && w_done_d) begin
               wr_en     = 1'b1;
               bvalid_d  = 1'b1;
               awready_d = 1'b0;
               wready_d  = 1'b0;
               w_state_d = W_RESP;
            end else begin
               awready_d = !aw_done_d;
               wready_d  = !w_done_d;
            end
         end
         W_RESP: begin
            awready_d = 1'b0;
            wready_d  = 1'b0;
            if (s_axi_bready) begin
               bvalid_d  = 1'b0;
               aw_done_d = 1'b0;
               w_done_d  = 1'b0;
               awready_d = 1'b1;
               wready_d  = 1'b1;
               w_state_d = W_IDLE;
            end
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   // Read channel: single outstanding read, data held until rready
   always_comb begin
      r_state_d = r_state_q;
      arready_d = arready_q;
      rvalid_d  = rvalid_q;
      rdata_d   = rdata_q;
      unique case (r_state_q)
         R_IDLE: begin
            arready_d = 1'b1;
            if (s_axi_arvalid && arready_q) begin
               rdata_d   = regs_q[s_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]];
               rvalid_d  = 1'b1;
               arready_d = 1'b0;
               r_state_d = R_DATA;
            end
         end
         R_DATA: begin
            arready_d = 1'b0;
            if (s_axi_rready) begin
               rvalid_d  = 1'b0;
               arready_d = 1'b1;
               r_state_d = R_IDLE;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         w_state_q  <= W_IDLE;
         aw_done_q  <= 1'b0;
         w_done_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         awready_q  <= 1'b0;
         wready_q   <= 1'b0;
         bvalid_q   <= 1'b0;
         r_state_q  <= R_IDLE;
         arready_q  <= 1'b0;
         rvalid_q   <= 1'b0;
         rdata_q    <= '0;
         scan_cnt_q <= '0;
         scan_idx_q <= '0;
         for (int r = 0; r < int'(NREG); r++) regs_q[r] <= '0;
      end else begin
         w_state_q <= w_state_d;
         aw_done_q <= aw_done_d;
         w_done_q  <= w_done_d;
         awaddr_q  <= awaddr_d;
         wdata_q   <= wdata_d;
         wstrb_q   <= wstrb_d;
         awready_q <= awready_d;
         wready_q  <= wready_d;
         bvalid_q  <= bvalid_d;
         r_state_q <= r_state_d;
         arready_q <= arready_d;
         rvalid_q  <= rvalid_d;
         rdata_q   <= rdata_d;
         if (wr_en) begin
            for (int b = 0; b < int'(SW); b++)
               if (wstrb_d[b]) regs_q[awaddr_d][8*b +: 8] <= wdata_d[8*b +: 8];
         end
         if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
            scan_cnt_q <= '0;
            scan_idx_q <= scan_idx_q + 2'd1;
         end else begin
            scan_cnt_q <= scan_cnt_q + CNT_W'(1);
         end
      end
   end

   // Active-low segments {g,f,e,d,c,b,a} for hex 0..F
   function automatic logic [6:0] seg7(input logic [3:0] n);
      case (n)
         4'h0: seg7 = 7'h40;
         4'h1: seg7 = 7'h79;
         4'h2: seg7 = 7'h24;
         4'h3: seg7 = 7'h30;
         4'h4: seg7 = 7'h19;
         4'h5: seg7 = 7'h12;
         4'h6: seg7 = 7'h02;
         4'h7: seg7 = 7'h78;
         4'h8: seg7 = 7'h00;
         4'h9: seg7 = 7'h10;
         4'hA: seg7 = 7'h08;
         4'hB: seg7 = 7'h03;
         4'hC: seg7 = 7'h46;
         4'hD: seg7 = 7'h21;
         4'hE: seg7 = 7'h06;
         default: seg7 = 7'h0E;
      endcase
   endfunction

   logic [3:0] digit;
   assign digit    = 4'(regs_q[1] >> {scan_idx_q, 2'b00});
   assign fnd_com  = regs_q[0][0] ? ~(4'b0001 << scan_idx_q) : 4'hF;
   assign fnd_font = regs_q[0][0] ? {~regs_q[2][scan_idx_q], seg7(digit)} : 8'hFF;

   assign s_axi_awready = awready_q;
   assign s_axi_wready  = wready_q;
   assign s_axi_bvalid  = bvalid_q;
   assign s_axi_bresp   = 2'b00;
   assign s_axi_arready = arready_q;
   assign s_axi_rvalid  = rvalid_q;
   assign s_axi_rdata   = rdata_q;
   assign s_axi_rresp   = 2'b00;

   logic unused_inputs;
   assign unused_inputs = ^{s_axi_awprot, s_axi_arprot, s_axi_awaddr[1:0], s_axi_araddr[1:0]};

endmodule

// File: tb/tb_fnd_axil_regs.sv
// Directed plus randomized bench for fnd_axil_regs with a register/display reference model.
module tb_fnd_axil_regs;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  s_axi_awaddr = '0;
   logic [2:0]  s_axi_awprot = '0;
   logic        s_axi_awvalid = 1'b0;
   logic        s_axi_awready;
   logic [31:0] s_axi_wdata = '0;
   logic [3:0]  s_axi_wstrb = '0;
   logic        s_axi_wvalid = 1'b0;
   logic        s_axi_wready;
   logic [1:0]  s_axi_bresp;
   logic        s_axi_bvalid;
   logic        s_axi_bready = 1'b1;
   logic [3:0]  s_axi_araddr = '0;
   logic [2:0]  s_axi_arprot = '0;
   logic        s_axi_arvalid = 1'b0;
   logic        s_axi_arready;
   logic [31:0] s_axi_rdata;
   logic [1:0]  s_axi_rresp;
   logic        s_axi_rvalid;
   logic        s_axi_rready = 1'b0;
   logic [3:0]  fnd_com;
   logic [7:0]  fnd_font;

   fnd_axil_regs #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .SCAN_DIV(4)) dut (
      .clock(clock), .reset(reset),
      .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
      .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
      .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
      .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
      .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
      .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
      .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
      .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
      .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
      .fnd_com(fnd_com), .fnd_font(fnd_font)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;
   int k = 0;
   logic [31:0] model [4];
   logic [7:0]  seg_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

   // Cycles since the last reset edge; the scan slot follows from this alone
   always @(posedge clock) begin
      if (reset) k <= 0;
      else       k <= k + 1;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] s);
      logic [31:0] r;
      r = old;
      for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = d[8*b +: 8];
      return r;
   endfunction

   task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
      int  t;
      bit  aw_ok, w_ok, aw_hs, w_hs;
      @(negedge clock);
      s_axi_awaddr = a; s_axi_awvalid = 1'b1;
      s_axi_wdata = d; s_axi_wstrb = s; s_axi_wvalid = 1'b1; s_axi_bready = 1'b1;
      aw_ok = 0; w_ok = 0; t = 0;
      while (!(aw_ok && w_ok) && t < 50) begin
         aw_hs = s_axi_awvalid && s_axi_awready;
         w_hs  = s_axi_wvalid && s_axi_wready;
         @(posedge clock);
         if (aw_hs) aw_ok = 1;
         if (w_hs)  w_ok = 1;
         @(negedge clock);
         if (aw_ok) s_axi_awvalid = 1'b0;
         if (w_ok)  s_axi_wvalid = 1'b0;
         t++;
      end
      chk("write_timeout", 32'(t < 50), 32'd1);
      chk("bvalid", 32'(s_axi_bvalid), 32'd1);
      chk("bresp", 32'(s_axi_bresp), 32'd0);
      @(negedge clock);
      model[a[3:2]] = merge(model[a[3:2]], d, s);
   endtask

   task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
      int t;
      @(negedge clock);
      s_axi_araddr = a; s_axi_arvalid = 1'b1; t = 0;
      while (!s_axi_arready && t < 50) begin
         @(negedge clock);
         t++;
      end
      chk("read_timeout", 32'(t < 50), 32'd1);
      @(negedge clock);
      s_axi_arvalid = 1'b0;
      chk("rvalid", 32'(s_axi_rvalid), 32'd1);
      chk("rresp", 32'(s_axi_rresp), 32'd0);
      d = s_axi_rdata;
      s_axi_rready = 1'b1;
      @(negedge clock);
      s_axi_rready = 1'b0;
   endtask

   task automatic read_check(input logic [3:0] a, input string tag);
      logic [31:0] d;
      axi_read(a, d);
      chk(tag, d, model[a[3:2]]);
   endtask

   task automatic check_display(input int n, input string tag);
      int idx;
      logic [7:0] ef;
      logic [3:0] ec;
      for (int c = 0; c < n; c++) begin
         @(negedge clock);
         idx = (k / 4) % 4;
         if (model[0][0]) begin
            ef = seg_tab[(model[1] >> (4 * idx)) & 32'hF];
            if (model[2][idx]) ef = ef & 8'h7F;
            ec = 4'hF ^ 4'(1 << idx);
         end else begin
            ef = 8'hFF;
            ec = 4'hF;
         end
         chk({tag, "_com"}, 32'(fnd_com), 32'(ec));
         chk({tag, "_font"}, 32'(fnd_font), 32'(ef));
      end
   endtask

   initial begin
      logic [31:0] d;
      for (int r = 0; r < 4; r++) model[r] = '0;

      // Reset state
      @(negedge clock);
      @(negedge clock);
      chk("rst_awready", 32'(s_axi_awready), 32'd0);
      chk("rst_wready", 32'(s_axi_wready), 32'd0);
      chk("rst_arready", 32'(s_axi_arready), 32'd0);
      chk("rst_bvalid", 32'(s_axi_bvalid), 32'd0);
      chk("rst_rvalid", 32'(s_axi_rvalid), 32'd0);
      chk("rst_rdata", s_axi_rdata, 32'd0);
      chk("rst_com", 32'(fnd_com), 32'hF);
      chk("rst_font", 32'(fnd_font), 32'hFF);
      reset = 1'b0;
      @(negedge clock);
      chk("post_awready", 32'(s_axi_awready), 32'd1);
      chk("post_wready", 32'(s_axi_wready), 32'd1);
      chk("post_arready", 32'(s_axi_arready), 32'd1);

      // Basic write/readback of all four registers
      axi_write(4'h0, 32'h1, 4'hF);
      axi_write(4'h4, 32'h2, 4'hF);
      axi_write(4'h8, 32'h3, 4'hF);
      axi_write(4'hC, 32'h4, 4'hF);
      for (int r = 0; r < 4; r++) read_check(4'(r * 4), "basic_rd");

      // Byte strobe
      axi_write(4'hC, 32'hFFFF_FFFF, 4'hF);
      axi_write(4'hC, 32'h00AB_0000, 4'b0100);
      axi_read(4'hC, d);
      chk("strobe_rd", d, 32'hFFAB_FFFF);

      // W presented three cycles ahead of AW
      @(negedge clock);
      s_axi_bready = 1'b0;
      s_axi_wdata = 32'h5555_AAAA; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      @(negedge clock);
      chk("wfirst_wready", 32'(s_axi_wready), 32'd0);
      chk("wfirst_bvalid", 32'(s_axi_bvalid), 32'd0);
      chk("wfirst_awready", 32'(s_axi_awready), 32'd1);
      s_axi_wvalid = 1'b0;
      @(negedge clock);
      @(negedge clock);
      s_axi_awaddr = 4'h4; s_axi_awvalid = 1'b1;
      @(negedge clock);
      chk("wfirst_bvalid_up", 32'(s_axi_bvalid), 32'd1);
      chk("wfirst_awready_lo", 32'(s_axi_awready), 32'd0);
      s_axi_awvalid = 1'b0; s_axi_bready = 1'b1;
      @(negedge clock);
      chk("wfirst_bvalid_dn", 32'(s_axi_bvalid), 32'd0);
      model[1] = 32'h5555_AAAA;
      read_check(4'h4, "wfirst_rd");

      // bready held low with a second AW waiting
      @(negedge clock);
      s_axi_bready = 1'b0;
      s_axi_awaddr = 4'hC; s_axi_awvalid = 1'b1;
      s_axi_wdata = 32'hDEAD_BEEF; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
      @(negedge clock);
      s_axi_wvalid = 1'b0;
      s_axi_awaddr = 4'h8;
      for (int c = 0; c < 5; c++) begin
         chk("hold_bvalid", 32'(s_axi_bvalid), 32'd1);
         chk("hold_awready", 32'(s_axi_awready), 32'd0);
         chk("hold_wready", 32'(s_axi_wready), 32'd0);
         @(negedge clock);
      end
      model[3] = 32'hDEAD_BEEF;
      s_axi_bready = 1'b1;
      @(negedge clock);
      chk("hold_bvalid_dn", 32'(s_axi_bvalid), 32'd0);
      chk("hold_awready_up", 32'(s_axi_awready), 32'd1);
      s_axi_wdata = 32'h0000_00F0; s_axi_wvalid = 1'b1;
      @(negedge clock);
      chk("hold_second_bvalid", 32'(s_axi_bvalid), 32'd1);
      s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
      @(negedge clock);
      model[2] = 32'h0000_00F0;
      read_check(4'hC, "hold_rd_first");
      read_check(4'h8, "hold_rd_second");

      // Randomized traffic against the register model
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 1) == 1)
            axi_write(4'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
         else
            read_check(4'($urandom_range(0, 15)), "rand_rd");
      end

      // Display scan
      axi_write(4'h0, 32'h1, 4'hF);
      axi_write(4'h4, 32'h0000_1234, 4'hF);
      axi_write(4'h8, 32'h2, 4'hF);
      check_display(20, "scan");
      axi_write(4'h4, $urandom, 4'hF);
      axi_write(4'h8, 32'($urandom_range(0, 15)), 4'hF);
      check_display(16, "scan_rand");
      axi_write(4'h0, 32'hFFFF_FFFE, 4'hF);
      check_display(8, "scan_off");

      // Reset while a read response is pending
      @(negedge clock);
      s_axi_araddr = 4'h4; s_axi_arvalid = 1'b1; s_axi_rready = 1'b0;
      @(negedge clock);
      s_axi_arvalid = 1'b0;
      chk("prerst_rvalid", 32'(s_axi_rvalid), 32'd1);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_rvalid", 32'(s_axi_rvalid), 32'd0);
      chk("midrst_rdata", s_axi_rdata, 32'd0);
      chk("midrst_com", 32'(fnd_com), 32'hF);
      reset = 1'b0;
      for (int r = 0; r < 4; r++) model[r] = '0;
      for (int r = 0; r < 4; r++) read_check(4'(r * 4), "postrst_rd");
      read_check(4'h0, "postrst_ctrl");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
